// File: rtl/palin_pkg.sv
// Shared types and constants for the palindrome / bit-reverse execute unit.
package palin_pkg;

  localparam int unsigned XLEN_P = 32;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned SH_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [MODE_W-1:0] MODE_BIT  = 2'd0;
  localparam logic [MODE_W-1:0] MODE_BYTE = 2'd1;
  localparam logic [MODE_W-1:0] MODE_NIB  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_REV  = 2'd3;

  // Number of symmetric element pairs walked for each mode.
  function automatic logic [IDX_W:0] pair_count(input logic [MODE_W-1:0] mode);
    case (mode)
      MODE_BYTE: pair_count = 5'd2;
      MODE_NIB:  pair_count = 5'd4;
      default:   pair_count = 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/palin_exec_unit_pair_cmp.sv
// Combinational pair evaluator: compares element idx with its mirror and
// produces the word with the mirrored bit pair swapped (used by reverse mode).
module palin_pair_cmp
  import palin_pkg::*;
(
  input  logic [XLEN_P-1:0] work,
  input  logic [MODE_W-1:0] mode,
  input  logic [IDX_W-1:0]  idx,
  output logic              pair_eq_c,
  output logic [XLEN_P-1:0] swapped_c
);

  logic [SH_W-1:0] lo_sh;
  logic [SH_W-1:0] hi_sh;
  logic [7:0]      mask;
  logic [7:0]      lo_v;
  logic [7:0]      hi_v;

  // Element offsets: low element at idx*E, mirror at XLEN-E-idx*E.
  always_comb begin
    lo_sh = SH_W'({1'b0, idx});
    hi_sh = 5'd31 - lo_sh;
    mask  = 8'h01;
    case (mode)
      MODE_BYTE: begin
        lo_sh = SH_W'({idx[0], 3'b000});
        hi_sh = 5'd24 - lo_sh;
        mask  = 8'hFF;
      end
      MODE_NIB: begin
        lo_sh = SH_W'({idx[1:0], 2'b00});
        hi_sh = 5'd28 - lo_sh;
        mask  = 8'h0F;
      end
      default: ;
    endcase
    lo_v      = 8'(work >> lo_sh) & mask;
    hi_v      = 8'(work >> hi_sh) & mask;
    pair_eq_c = (lo_v == hi_v);
    swapped_c        = work;
    swapped_c[lo_sh] = work[hi_sh];
    swapped_c[hi_sh] = work[lo_sh];
  end

endmodule

// File: rtl/palin_exec_unit.sv
// Multi-cycle execute unit for the palindrome and bit-reverse instructions:
// one element pair per cycle, stalls the core via busy, one-cycle writeback.
module palin_exec_unit
  import palin_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [XLEN-1:0]   op_a,
  input  logic [4:0]        rd_in,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic              wb_en,
  output logic [4:0]        rd_out
);

  if (XLEN != 32) begin : g_xlen_check
    $error("palin_exec_unit: only XLEN=32 is supported");
  end

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [XLEN-1:0]     work_q, work_d;
  logic                match_q, match_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [RD_W-1:0]     rd_q, rd_d;
  logic                busy_d, done_d, wb_en_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                busy_q, done_q, wb_en_q;

  logic                pair_eq_c;
  logic [XLEN-1:0]     swapped_c;
  logic                is_cmp_c;
  logic                last_c;
  logic                finish_c;

  palin_pair_cmp u_pair_cmp (
    .work      (work_q),
    .mode      (mode_q),
    .idx       (idx_q),
    .pair_eq_c (pair_eq_c),
    .swapped_c (swapped_c)
  );

  assign is_cmp_c = (mode_q != MODE_REV);
  assign last_c   = (idx_q == IDX_W'(pair_count(mode_q) - 5'd1));
  assign finish_c = last_c || (is_cmp_c && !pair_eq_c && EARLY_EXIT);

  // Next-state and registered-output decode.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    work_d   = work_q;
    match_d  = match_q;
    mode_d   = mode_q;
    rd_d     = rd_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    wb_en_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = op_a;
          mode_d  = mode;
          rd_d    = rd_in;
          idx_d   = '0;
          match_d = 1'b1;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (is_cmp_c && !pair_eq_c) match_d = 1'b0;
        if (!is_cmp_c) work_d = swapped_c;
        if (finish_c) begin
          busy_d   = 1'b0;
          done_d   = 1'b1;
          wb_en_d  = (rd_q != '0);
          result_d = is_cmp_c ? {{(XLEN-1){1'b0}}, match_d} : work_d;
          state_d  = DONE;
        end else begin
          idx_d = IDX_W'(idx_q + 4'd1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      work_q   <= '0;
      match_q  <= 1'b0;
      mode_q   <= '0;
      rd_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wb_en_q  <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      work_q   <= work_d;
      match_q  <= match_d;
      mode_q   <= mode_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wb_en_q  <= wb_en_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign wb_en  = wb_en_q;
  assign result = result_q;
  assign rd_out = rd_q;

endmodule
